// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache block fill controller: issues block reads, writes returned words and the tag
//
// Purpose: on a cache miss, fetch the whole aligned block from memory one 16-bit
// word per cycle, write each returned word into the data array, and write the
// tag/valid bit together with the last word.
//
// Ports:
//   clk               - clock, rising edge
//   rst               - asynchronous active-high reset
//   miss_detected     - cache miss this cycle
//   miss_address      - byte address of the missing access
//   memory_data_valid - memory returns one word this cycle
//   memory_data       - returned word (routed straight to the data array)
//   fsm_busy          - pipeline stall request
//   mem_en            - issue a memory read this cycle
//   memory_address    - read address issued with mem_en
//   write_data_array  - write memory_data into the data array this cycle
//   fill_address      - data-array byte address for write_data_array
//   write_tag_array   - write tag and valid bit for the block this cycle

module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        mem_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [15:0] fill_address,
    output logic        write_tag_array
);

    localparam int CW = $clog2(BLOCK_WORDS) + 1;
    // A block spans BLOCK_WORDS*2 bytes, so log2(BLOCK_WORDS)+1 offset bits are cleared.
    localparam logic [15:0] BASE_MASK = 16'hFFFF << CW;
    localparam logic [CW-1:0] FULL = CW'(BLOCK_WORDS);
    localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t        state, state_next;
    logic [15:0]   base, base_next;
    logic [CW-1:0] issue_cnt, issue_next;
    logic [CW-1:0] recv_cnt, recv_next;

    // The returned word travels directly from memory to the data array.
    logic unused_memory_data;
    assign unused_memory_data = ^memory_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base      <= 16'h0000;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state     <= state_next;
            base      <= base_next;
            issue_cnt <= issue_next;
            recv_cnt  <= recv_next;
        end
    end

    always_comb begin
        state_next       = state;
        base_next        = base;
        issue_next       = issue_cnt;
        recv_next        = recv_cnt;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = base;
        write_data_array = 1'b0;
        fill_address     = base;
        write_tag_array  = 1'b0;

        case (state)
            IDLE: begin
                if (miss_detected) begin
                    fsm_busy   = 1'b1;
                    base_next  = miss_address & BASE_MASK;
                    issue_next = '0;
                    recv_next  = '0;
                    state_next = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                // Reads stream out back-to-back regardless of how fast data returns.
                if (issue_cnt < FULL) begin
                    mem_en         = 1'b1;
                    memory_address = base + 16'({issue_cnt, 1'b0});
                    issue_next     = issue_cnt + CW'(1);
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_address     = base + 16'({recv_cnt, 1'b0});
                    recv_next        = recv_cnt + CW'(1);
                    if (recv_cnt == LAST) begin
                        write_tag_array = 1'b1;
                        state_next      = IDLE;
                    end
                end
            end
        endcase
    end

endmodule
